instruction_cache_controller: RTL

INSTRUCTION_CACHE_CONTROLLER -- requirements
Module: instruction_cache_controller

---
 rtl/instruction_cache_controller_pkg.sv | 30 +++
 rtl/instruction_cache_controller_array.sv | 46 ++++
 rtl/instruction_cache_controller.sv | 107 ++++++++++
 3 files changed

// File: rtl/instruction_cache_controller_pkg.sv
// Shared types and widths for the direct-mapped instruction cache.
// Holds the controller state encoding and a word-select helper for 128-bit blocks.
package instruction_cache_controller_pkg;

   localparam int ADDR_W     = 10;
   localparam int BLOCK_W    = 128;
   localparam int WORD_W     = 32;
   localparam int MEM_ADDR_W = 6;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      MEM_READ = 2'd1,
      UPDATE   = 2'd2
   } state_t;

   function automatic logic [WORD_W-1:0] select_word(input logic [BLOCK_W-1:0] blk,
                                                     input logic [1:0]         sel);
      logic [WORD_W-1:0] w_word;
      w_word = blk[31:0];
      case (sel)
         2'd0: w_word = blk[31:0];
         2'd1: w_word = blk[63:32];
         2'd2: w_word = blk[95:64];
         2'd3: w_word = blk[127:96];
         default: w_word = blk[31:0];
      endcase
      return w_word;
   endfunction

endpackage

// File: rtl/instruction_cache_controller_array.sv
// Valid/tag/data storage: combinational read port, single write port on the clock.
// Only valid bits are reset; tag and data contents are meaningless until valid is set.
module instruction_cache_controller_array
   import instruction_cache_controller_pkg::*;
#(
   parameter int INDEX_BITS = 3,
   parameter int TAG_W      = 3
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic [INDEX_BITS-1:0] i_rd_index,
   output logic                  o_rd_valid,
   output logic [TAG_W-1:0]      o_rd_tag,
   output logic [BLOCK_W-1:0]    o_rd_block,
   input  logic                  i_wr_en,
   input  logic [INDEX_BITS-1:0] i_wr_index,
   input  logic [TAG_W-1:0]      i_wr_tag,
   input  logic [BLOCK_W-1:0]    i_wr_block
);

   localparam int DEPTH = 1 << INDEX_BITS;

   logic [DEPTH-1:0]   r_valid;
   logic [TAG_W-1:0]   r_tag  [DEPTH];
   logic [BLOCK_W-1:0] r_data [DEPTH];

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_valid <= '0;
      end else if (i_wr_en) begin
         r_valid[i_wr_index] <= 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (i_wr_en) begin
         r_tag[i_wr_index]  <= i_wr_tag;
         r_data[i_wr_index] <= i_wr_block;
      end
   end

   assign o_rd_valid = r_valid[i_rd_index];
   assign o_rd_tag   = r_tag[i_rd_index];
   assign o_rd_block = r_data[i_rd_index];

endmodule

// File: rtl/instruction_cache_controller.sv
// Direct-mapped read-only instruction cache: hits return the word combinationally with no stall.
// Misses stall the CPU for 1 + memory cycles + 1, then the re-evaluated access hits.
module instruction_cache_controller
   import instruction_cache_controller_pkg::*;
#(
   parameter int INDEX_BITS = 3
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  cpu_read,
   input  logic [ADDR_W-1:0]     pc_address,
   output logic [WORD_W-1:0]     instruction,
   output logic                  busywait,
   output logic                  mem_read,
   output logic [MEM_ADDR_W-1:0] mem_address,
   input  logic [BLOCK_W-1:0]    mem_readinst,
   input  logic                  mem_busywait
);

   localparam int TAG_W = MEM_ADDR_W - INDEX_BITS;

   state_t                  r_state;
   state_t                  w_next_state;
   logic [MEM_ADDR_W-1:0]   r_miss_addr;
   logic                    w_latch_miss;
   logic                    w_wr_en;

   logic [TAG_W-1:0]        w_tag;
   logic [INDEX_BITS-1:0]   w_index;
   logic [1:0]              w_word;
   logic                    w_unused_byte_sel;

   logic                    w_rd_valid;
   logic [TAG_W-1:0]        w_rd_tag;
   logic [BLOCK_W-1:0]      w_rd_block;
   logic                    w_hit;

   assign w_tag             = pc_address[ADDR_W-1:4+INDEX_BITS];
   assign w_index           = pc_address[3+INDEX_BITS:4];
   assign w_word            = pc_address[3:2];
   assign w_unused_byte_sel = ^pc_address[1:0];

   instruction_cache_controller_array #(
      .INDEX_BITS (INDEX_BITS),
      .TAG_W      (TAG_W)
   ) u_array (
      .clock      (clock),
      .reset_n    (reset_n),
      .i_rd_index (w_index),
      .o_rd_valid (w_rd_valid),
      .o_rd_tag   (w_rd_tag),
      .o_rd_block (w_rd_block),
      .i_wr_en    (w_wr_en),
      .i_wr_index (r_miss_addr[INDEX_BITS-1:0]),
      .i_wr_tag   (r_miss_addr[MEM_ADDR_W-1:INDEX_BITS]),
      .i_wr_block (mem_readinst)
   );

   assign w_hit       = cpu_read & w_rd_valid & (w_rd_tag == w_tag);
   assign instruction = select_word(w_rd_block, w_word);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= IDLE;
         r_miss_addr <= '0;
      end else begin
         r_state <= w_next_state;
         if (w_latch_miss) begin
            r_miss_addr <= pc_address[ADDR_W-1:4];
         end
      end
   end

   // The fill write happens on the same edge that leaves MEM_READ, so reset aborts it cleanly.
   always_comb begin
      w_next_state = r_state;
      busywait     = 1'b0;
      mem_read     = 1'b0;
      mem_address  = '0;
      w_latch_miss = 1'b0;
      w_wr_en      = 1'b0;
      case (r_state)
         IDLE: begin
            busywait = cpu_read & ~w_hit;
            if (cpu_read && !w_hit) begin
               w_latch_miss = 1'b1;
               w_next_state = MEM_READ;
            end
         end
         MEM_READ: begin
            busywait    = 1'b1;
            mem_read    = 1'b1;
            mem_address = r_miss_addr;
            if (!mem_busywait) begin
               w_wr_en      = 1'b1;
               w_next_state = UPDATE;
            end
         end
         UPDATE: begin
            busywait     = 1'b1;
            w_next_state = IDLE;
         end
         default: w_next_state = IDLE;
      endcase
   end

endmodule
